// File: rtl/wisc_pkg.sv
// Shared types for the flag/branch path: condition codes, resolver FSM states,
// and the bit positions of N, V and Z inside the 3-bit flag vector.
package wisc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IMM_W  = 9;
  localparam int unsigned FLAG_W = 3;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [2:0] {
    NE     = 3'b000,
    EQ     = 3'b001,
    GT     = 3'b010,
    LT     = 3'b011,
    GE     = 3'b100,
    LE     = 3'b101,
    OVF    = 3'b110,
    UNCOND = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational evaluation of a branch condition code against {N,V,Z}.
module branch_cond_eval
  import wisc_pkg::*;
(
  input  cond_e             cond_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic              taken_o
);

  logic n, v, z;

  assign n = flags_i[FLAG_N];
  assign v = flags_i[FLAG_V];
  assign z = flags_i[FLAG_Z];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      NE:      taken_o = ~z;
      EQ:      taken_o = z;
      GT:      taken_o = ~z & ~n;
      LT:      taken_o = n;
      GE:      taken_o = z | ~n;
      LE:      taken_o = n | z;
      OVF:     taken_o = v;
      UNCOND:  taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural N/V/Z register plus conditional-branch resolver for B/BR.
// Define FLAG_BYPASS_EN to forward the EX flag result into condition evaluation.
module flag_branch_unit
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [FLAG_W-1:0] ex_nvz,
  input  logic              ex_wr_nv,
  input  logic              ex_wr_z,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic              br_is_reg,
  input  logic [DATA_W-1:0] br_pc_plus2,
  input  logic [IMM_W-1:0]  br_imm9,
  input  logic [DATA_W-1:0] br_reg,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              br_done,
  output logic              dec_stall,
  output logic [FLAG_W-1:0] flags_q
);

  state_e              state_q, state_d;
  logic [FLAG_W-1:0]   flags_d;
  logic [FLAG_W-1:0]   eff_flags;
  logic                hazard;
  logic                commit;
  logic                resolvable;
  logic                taken;
  logic [DATA_W-1:0]   imm_ofs;
  logic [DATA_W-1:0]   target;

  assign hazard = ex_valid & (ex_wr_nv | ex_wr_z);
  assign commit = ex_valid & ~ex_stall;

  // Flag commit: a full NVZ write wins over a Z-only write.
  always_comb begin
    flags_d = flags_q;
    if (commit) begin
      if (ex_wr_nv) begin
        flags_d = ex_nvz;
      end else if (ex_wr_z) begin
        flags_d[FLAG_Z] = ex_nvz[FLAG_Z];
      end
    end
  end

`ifdef FLAG_BYPASS_EN
  // flags_d already equals flags_q unless an unstalled EX write is in flight.
  assign eff_flags  = flags_d;
  assign resolvable = ~hazard | ~ex_stall;
`else
  assign eff_flags  = flags_q;
  assign resolvable = ~hazard;
`endif

  branch_cond_eval u_cond (
    .cond_i  (cond_e'(br_cond)),
    .flags_i (eff_flags),
    .taken_o (taken)
  );

  // Word offset scaled to bytes: sign-extend, shift left by one.
  assign imm_ofs = {{(DATA_W-IMM_W-1){br_imm9[IMM_W-1]}}, br_imm9, 1'b0};
  assign target  = br_is_reg ? br_reg : DATA_W'(br_pc_plus2 + imm_ofs);

  always_comb begin
    state_d  = state_q;
    br_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (resolvable) begin
            br_ready = 1'b1;
            state_d  = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!br_valid || resolvable) begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dec_stall = br_valid & ~br_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      flags_q        <= '0;
      br_done        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      flags_q        <= flags_d;
      br_done        <= br_ready;
      redirect_valid <= br_ready & taken;
      redirect_pc    <= (br_ready & taken) ? target : '0;
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: reference model checked every cycle plus literal spot checks.
module tb_flag_branch_unit;

  localparam logic [2:0] C_NE = 3'd0, C_EQ = 3'd1, C_GT = 3'd2, C_UNC = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_stall, ex_wr_nv, ex_wr_z;
  logic [2:0]  ex_nvz;
  logic        br_valid, br_ready, br_is_reg;
  logic [2:0]  br_cond;
  logic [15:0] br_pc_plus2, br_reg;
  logic [8:0]  br_imm9;
  logic        redirect_valid, br_done, dec_stall;
  logic [15:0] redirect_pc;
  logic [2:0]  flags_q;

  int n_checks = 0;
  int n_pass   = 0;

  flag_branch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_nvz(ex_nvz),
    .ex_wr_nv(ex_wr_nv), .ex_wr_z(ex_wr_z),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_is_reg(br_is_reg), .br_pc_plus2(br_pc_plus2), .br_imm9(br_imm9),
    .br_reg(br_reg), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_done(br_done), .dec_stall(dec_stall), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] f);
    logic n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] b_target(input logic [15:0] pc, input logic [8:0] imm);
    int off;
    off = imm[8] ? int'(imm) - 512 : int'(imm);
    return 16'(int'(pc) + 2 * off);
  endfunction

  // Reference model: flags, "response due this cycle", "branch refused last cycle".
  logic [2:0]  m_flags = '0;
  logic        m_resp = 1'b0, m_wait = 1'b0;
  logic        e_done = 1'b0, e_rv = 1'b0;
  logic [15:0] e_pc = '0;

  always @(negedge clk) begin : model
    logic       haz, res, exp_ready, tk;
    logic [2:0] post, eff;
    if (!rst_n) begin
      m_flags = '0; m_resp = 1'b0; m_wait = 1'b0;
      e_done = 1'b0; e_rv = 1'b0; e_pc = '0;
    end
    haz  = ex_valid && (ex_wr_nv || ex_wr_z);
    post = m_flags;
    if (ex_valid && !ex_stall) begin
      if (ex_wr_nv)     post = ex_nvz;
      else if (ex_wr_z) post = {m_flags[2:1], ex_nvz[0]};
    end
`ifdef FLAG_BYPASS_EN
    res = !haz || !ex_stall;
    eff = post;
`else
    res = !haz;
    eff = m_flags;
`endif
    exp_ready = !m_resp && !m_wait && br_valid && res;
    check("br_ready", br_ready, exp_ready);
    check("dec_stall", dec_stall, br_valid && !exp_ready);
    check("br_done", br_done, e_done);
    check("redirect_valid", redirect_valid, e_rv);
    check("redirect_pc", redirect_pc, e_pc);
    check("flags_q", flags_q, m_flags);
    if (rst_n) begin
      tk     = cond_holds(br_cond, eff);
      e_done = exp_ready;
      e_rv   = exp_ready && tk;
      e_pc   = (exp_ready && tk) ? (br_is_reg ? br_reg : b_target(br_pc_plus2, br_imm9)) : 16'h0;
      m_wait = !m_resp && br_valid && !res;
      m_resp = exp_ready;
      m_flags = post;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ex_set(input logic v, input logic wnv, input logic wz, input logic st,
                        input logic [2:0] nvz);
    ex_valid = v; ex_wr_nv = wnv; ex_wr_z = wz; ex_stall = st; ex_nvz = nvz;
  endtask

  task automatic br_set(input logic v, input logic [2:0] c, input logic isr,
                        input logic [15:0] pc, input logic [8:0] imm, input logic [15:0] r);
    br_valid = v; br_cond = c; br_is_reg = isr; br_pc_plus2 = pc; br_imm9 = imm; br_reg = r;
  endtask

  task automatic wait_ready(input int max_cyc);
    int n;
    n = 0;
    #1;
    while (!br_ready && n < max_cyc) begin
      @(posedge clk); #2;
      n++;
    end
    check("accept_within_bound", br_ready, 1);
  endtask

  initial begin #200000; $display("FAIL watchdog: timeout"); $fatal(1); end

  initial begin
    rst_n = 1'b0;
    ex_set(0, 0, 0, 0, 3'b000);
    br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0);
    repeat (3) step();
    check("rst_flags", flags_q, 3'b000);
    check("rst_done", br_done, 0);
    check("rst_rv", redirect_valid, 0);
    rst_n = 1'b1;

    // Flag commits
    ex_set(1, 1, 0, 0, 3'b110); step(); check("commit_nv", flags_q, 3'b110);
    ex_set(1, 0, 1, 0, 3'b001); step(); check("commit_z", flags_q, 3'b111);
    ex_set(1, 1, 1, 0, 3'b000); step(); check("nv_dominates", flags_q, 3'b000);
    ex_set(1, 1, 0, 1, 3'b010); step(); check("stall_hold", flags_q, 3'b000);
    ex_set(1, 0, 1, 0, 3'b001); step(); check("z_set", flags_q, 3'b001);
    ex_set(0, 0, 0, 0, 3'b000);

    // B EQ taken with backward offset
    br_set(1, C_EQ, 0, 16'h0010, 9'h1FE, 16'h0); #1;
    check("b_eq_ready", br_ready, 1);
    step(); br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0);
    check("b_eq_done", br_done, 1);
    check("b_eq_rv", redirect_valid, 1);
    check("b_eq_pc", redirect_pc, 16'h000C);
    step();

    // B GT not taken, then BR presented during RESP
    br_set(1, C_GT, 0, 16'h0020, 9'h010, 16'h0); step();
    check("b_gt_done", br_done, 1);
    check("b_gt_rv", redirect_valid, 0);
    check("b_gt_pc", redirect_pc, 16'h0000);
    br_set(1, C_UNC, 1, 16'h0, 9'h0, 16'hBEEF); #1;
    check("resp_no_accept", br_ready, 0);
    step(); check("br_accept", br_ready, 1);
    step(); br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0);
    check("br_rv", redirect_valid, 1);
    check("br_pc", redirect_pc, 16'hBEEF);
    step();

    // SUB producing Z=1 in EX while B EQ sits in decode
    ex_set(1, 1, 0, 0, 3'b000); step();
    ex_set(1, 1, 0, 0, 3'b001);
    br_set(1, C_EQ, 0, 16'h0100, 9'h004, 16'h0); #1;
`ifdef FLAG_BYPASS_EN
    check("byp_ready", br_ready, 1);
    step(); ex_set(0, 0, 0, 0, 3'b000); br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0);
    check("byp_rv", redirect_valid, 1);
    check("byp_pc", redirect_pc, 16'h0108);
`else
    check("haz_ready", br_ready, 0);
    check("haz_stall", dec_stall, 1);
    step(); ex_set(0, 0, 0, 0, 3'b000);
    check("haz_flags", flags_q, 3'b001); #1;
    check("wait_ready", br_ready, 0);
    step(); #1; check("post_wait_ready", br_ready, 1);
    step(); br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0);
    check("haz_rv", redirect_valid, 1);
    check("haz_pc", redirect_pc, 16'h0108);
`endif
    step();

    // Wrap-around target
    br_set(1, C_UNC, 0, 16'hFFFE, 9'h002, 16'h0); step();
    br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0);
    check("wrap_pc", redirect_pc, 16'h0002);
    step();

    // EX stalled on a flag writer for 3 cycles
    ex_set(1, 1, 0, 1, 3'b100);
    br_set(1, C_NE, 0, 16'h0200, 9'h1F0, 16'h0);
    repeat (3) begin
      #1; check("stall_dec", dec_stall, 1);
      step(); check("stall_flags", flags_q, 3'b001);
    end
    ex_set(1, 1, 0, 0, 3'b100); step();
    ex_set(0, 0, 0, 0, 3'b000);
    check("released_flags", flags_q, 3'b100);
    wait_ready(5);
    step(); br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0);
    check("ne_rv", redirect_valid, 1);
    check("ne_pc", redirect_pc, 16'h01E0);
    step();

    // Branch withdrawn while waiting
    ex_set(1, 1, 0, 1, 3'b010);
    br_set(1, C_EQ, 0, 16'h0300, 9'h002, 16'h0);
    step(); step();
    br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0); step();
    ex_set(0, 0, 0, 0, 3'b000); step();
    check("withdraw_done", br_done, 0);
    check("withdraw_flags", flags_q, 3'b100);

    // Reset during RESP
    br_set(1, C_UNC, 1, 16'h0, 9'h0, 16'h1234); #1;
    check("pre_rst_ready", br_ready, 1);
    step(); br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0);
    check("pre_rst_rv", redirect_valid, 1);
    rst_n = 1'b0; #1;
    check("midrst_flags", flags_q, 3'b000);
    check("midrst_rv", redirect_valid, 0);
    check("midrst_done", br_done, 0);
    check("midrst_ready", br_ready, 0);
    step(); step();
    rst_n = 1'b1; step();

    // Post-reset branch from IDLE, Z=0 so EQ not taken
    br_set(1, C_EQ, 0, 16'h0010, 9'h1FE, 16'h0); step();
    br_set(0, 3'd0, 0, 16'h0, 9'h0, 16'h0);
    check("post_rst_done", br_done, 1);
    check("post_rst_rv", redirect_valid, 0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Execute-stage consumer of the ALU's NVZ results: holds the architectural N/V/Z flag register, commits flag updates from ALU instructions leaving EX, and resolves conditional branches (B, BR) issued from decode against those flags. Produces a one-cycle registered redirect/flush pulse toward fetch and stalls decode while a branch's flags are not yet known. Sits directly downstream of the ALU and beside the ID/EX pipeline register.

## Interface
Parameters
- none (width fixed at 16)

Ports
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a live instruction
- ex_stall  in  1  EX held this cycle; no flag commit
- ex_nvz  in  3  computed flags {N,V,Z} from ALU for EX instruction
- ex_wr_nv  in  1  EX instruction writes N,V,Z (ADD/SUB)
- ex_wr_z  in  1  EX instruction writes Z only (other ALU ops)
- br_valid  in  1  decode presents a branch
- br_ready  out  1  branch accepted this cycle
- br_cond  in  3  condition code
- br_is_reg  in  1  1=BR (register target), 0=B (PC-relative)
- br_pc_plus2  in  16  PC of branch + 2
- br_imm9  in  9  signed word offset (B)
- br_reg  in  16  target register value (BR)
- redirect_valid  out  1  taken branch; also fetch/decode flush
- redirect_pc  out  16  target PC
- br_done  out  1  branch resolved (taken or not)
- dec_stall  out  1  decode must hold
- flags_q  out  3  architectural {N,V,Z}

Reset: as decided, clk single clock, rst_n asynchronous active-low. All outputs and flag register reset to 0; state IDLE.

## Operation
- Flag commit when ex_valid & ~ex_stall: ex_wr_nv → flags_q <= ex_nvz; else ex_wr_z → Z <= ex_nvz[0], N,V held; else no change. ex_wr_nv dominates ex_wr_z.
- Flag hazard = ex_valid & (ex_wr_nv | ex_wr_z).
- Effective flags: flags_q merged with pending EX update when bypass enabled and hazard & ~ex_stall; otherwise flags_q.
- Conditions: 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GE Z=1|N=0; 101 LE N=1|Z=1; 110 OVF V=1; 111 always.
- Target: B → br_pc_plus2 + (sext(br_imm9) << 1), mod 2^16 wrap; BR → br_reg.
- FSM:
  - IDLE: br_valid & resolvable → accept (br_ready=1), register result, go RESP. br_valid & not resolvable → WAIT.
  - WAIT: br_ready=0, dec_stall=1; exit to IDLE-resolve path when hazard clears (flags committed).
  - RESP: br_done=1 for exactly one cycle; redirect_valid=taken; br_ready=0; return IDLE.
- Resolvable: no hazard, or (bypass enabled and ~ex_stall).
- dec_stall = br_valid & ~br_ready.

## Timing
- Accept cycle T → br_done/redirect_valid/redirect_pc valid at T+1 for one cycle; outputs registered.
- Branch uses flags including any commit occurring in cycle T only under bypass; without bypass, a hazard costs ≥1 WAIT cycle.
- No branch accepted in RESP (younger instructions are being flushed).
- ex_stall high holds WAIT indefinitely; flags unchanged.
- br_valid dropped while in WAIT → return IDLE, nothing issued.
- rst_n low mid-branch: immediate return to IDLE, pulses cleared, flags 000.
- redirect_pc = 0 when not taken.

## Configuration
- FLAG_BYPASS_EN defined: EX flag result forwarded combinationally to condition evaluation; branch behind a flag-setting instruction resolves with no bubble.
- Undefined: no forwarding; any flag hazard forces WAIT until commit, then resolves from flags_q.

## Structure
- Shared package wisc_pkg: condition code enum (NE..UNCOND), FSM state enum (IDLE, WAIT, RESP), flag bit index constants N=2,V=1,Z=0.
- One combinational sub-module branch_cond_eval (cond, flags → taken).

## Test plan
- Reset: assert rst_n=0 mid-RESP → flags_q=000, redirect_valid=0, br_ready=0, state IDLE.
- Commit: ex_wr_nv, ex_nvz=110 then ex_wr_z, ex_nvz=001 → flags_q 110 then 111.
- B EQ, Z=1, pc_plus2=0x0010, imm9=0x1FE (−2) → next cycle redirect_valid=1, redirect_pc=0x000C.
- B GT with Z=1 → br_done=1, redirect_valid=0; BR uncond br_reg=0xBEEF → redirect_pc=0xBEEF.
- SUB producing Z=1 in EX while B EQ in decode: bypass → accepted same cycle, taken; no bypass → one WAIT cycle, then taken.
- Wrap: pc_plus2=0xFFFE, imm9=0x002 → redirect_pc=0x0002; ex_stall held 3 cycles during hazard → dec_stall=1 throughout, flags unchanged.
